// File: rtl/axis_rr_arbiter.sv
// Round-robin, packet-locking arbiter driving the en/ctrl selects of an AXIS N:1 mux.
// A grant is held until a TLAST beat or, optionally, a fixed beat count.
module axis_rr_arbiter #(
  parameter int unsigned CHANNEL_NUMBER       = 5,
  parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int unsigned MAX_BEATS            = 0,
  parameter int unsigned BEAT_CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNEL_NUMBER-1:0]       in_tvalid,
  input  logic                            out_tvalid,
  input  logic                            out_tready,
  input  logic                            out_tlast,
  output logic                            en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic                            busy
);

  localparam int unsigned CW = CHANNEL_NUMBER_WIDTH;
  localparam int unsigned BW = BEAT_CNT_WIDTH;
  // Counter value seen on the final allowed beat (counter holds beats already taken).
  localparam logic [BW-1:0] LAST_BEAT = BW'((MAX_BEATS > 0) ? (MAX_BEATS - 1) : 0);
  localparam logic [CW-1:0] LAST_CH   = CW'(CHANNEL_NUMBER - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            en_q, en_d;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            pick_valid;
  logic [CW-1:0]   pick_idx;
  logic [CW-1:0]   cand;
  logic            beat;
  logic            release_beat;

  // Rotating priority search starting just after the last granted channel.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= CHANNEL_NUMBER; i++) begin
      cand = CW'((32'(last_grant_q) + i) % CHANNEL_NUMBER);
      if (!pick_valid && in_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Handshake on the mux output and packet-end detection.
  always_comb begin
    beat         = (state_q == ST_GRANT) && out_tvalid && out_tready;
    release_beat = beat && (out_tlast || ((MAX_BEATS != 0) && (beat_cnt_q == LAST_BEAT)));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    ctrl_d       = ctrl_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_GRANT;
          en_d         = 1'b1;
          ctrl_d       = pick_idx;
          last_grant_d = pick_idx;
          beat_cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_beat) begin
          beat_cnt_d = '0;
          if (pick_valid) begin
            ctrl_d       = pick_idx;
            last_grant_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
          end
        end else if (beat && (beat_cnt_q != {BW{1'b1}})) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves channel 0 at top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      en_q         <= 1'b0;
      ctrl_q       <= '0;
      last_grant_q <= LAST_CH;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      ctrl_q       <= ctrl_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign en   = en_q;
  assign ctrl = ctrl_q;
  assign busy = en_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed testbench for axis_rr_arbiter: one instance with TLAST-only release,
// one with a two-beat limit, both driven by the same stimulus.
module tb_axis_rr_arbiter;

  localparam int unsigned N  = 5;
  localparam int unsigned CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_tvalid;
  logic          out_tvalid;
  logic          out_tready;
  logic          out_tlast;
  logic          en0, busy0, en2, busy2;
  logic [CW-1:0] ctrl0, ctrl2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_rr_arbiter #(.CHANNEL_NUMBER(N), .MAX_BEATS(0), .BEAT_CNT_WIDTH(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast),
    .en(en0), .ctrl(ctrl0), .busy(busy0)
  );

  axis_rr_arbiter #(.CHANNEL_NUMBER(N), .MAX_BEATS(2), .BEAT_CNT_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast),
    .en(en2), .ctrl(ctrl2), .busy(busy2)
  );

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are driven after a falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic r, input logic l);
    out_tvalid = v;
    out_tready = r;
    out_tlast  = l;
  endtask

  int seq[6] = '{1, 2, 4, 1, 2, 4};

  initial begin
    rst = 1'b1; in_tvalid = '0; drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_en", 32'(en0), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_ctrl", 32'(ctrl0), 0);
    rst = 1'b0;

    // No requests: stay idle.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_en", 32'(en0), 0);
      check("idle_ctrl", 32'(ctrl0), 0);
    end

    // Channels 1,2,4 with 3-beat packets, zero-bubble handoff.
    in_tvalid = 5'b10110;
    tick();
    for (int p = 0; p < 6; p++) begin
      for (int b = 0; b < 3; b++) begin
        check("rr_ctrl", 32'(ctrl0), 32'(seq[p]));
        check("rr_en", 32'(en0), 1);
        drive(1'b1, 1'b1, b == 2);
        if (p == 5 && b == 2) in_tvalid = '0;
        tick();
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    check("rr_end_en", 32'(en0), 0);
    check("rr_end_busy", 32'(busy0), 0);
    check("rr_end_ctrl_hold", 32'(ctrl0), 4);

    // Single requester ch3, stalled handshakes; TLAST held while stalled.
    in_tvalid = 5'b01000;
    tick();
    for (int c = 0; c < 7; c++) begin
      check("stall_en", 32'(en0), 1);
      check("stall_ctrl", 32'(ctrl0), 3);
      drive(1'b1, (c % 2) == 0, c >= 5);
      if (c == 6) in_tvalid = '0;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    check("stall_release_en", 32'(en0), 0);

    // Release on ch4 while ch0 first raises valid: handoff to ch0.
    in_tvalid = 5'b10000;
    tick();
    check("wrap_ctrl4", 32'(ctrl0), 4);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1);
    in_tvalid = 5'b10001;
    tick();
    check("wrap_en", 32'(en0), 1);
    check("wrap_ctrl0", 32'(ctrl0), 0);
    in_tvalid = 5'b00000;
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("wrap_idle_en", 32'(en0), 0);

    // Reset with all channels requesting, then first grant goes to ch0.
    rst = 1'b1; in_tvalid = 5'b11111;
    tick();
    check("allreq_rst_en", 32'(en0), 0);
    rst = 1'b0;
    tick();
    check("allreq_en", 32'(en0), 1);
    check("allreq_ctrl", 32'(ctrl0), 0);

    // Reset during beat 2 of a 5-beat packet.
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("midrst_beat1_ctrl", 32'(ctrl0), 0);
    rst = 1'b1;
    tick();
    check("midrst_en", 32'(en0), 0);
    check("midrst_ctrl", 32'(ctrl0), 0);
    rst = 1'b0; drive(1'b0, 1'b0, 1'b0);
    tick();
    check("midrst_regrant_en", 32'(en0), 1);
    check("midrst_regrant_ctrl", 32'(ctrl0), 0);

    // Beat limit of 2 on the second instance: ch0/ch1 alternate; no TLAST.
    rst = 1'b1; in_tvalid = '0;
    tick();
    rst = 1'b0; in_tvalid = 5'b00011;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("maxb_en", 32'(en2), 1);
      check("maxb_ctrl", 32'(ctrl2), 32'((k / 2) % 2));
      check("nolimit_ctrl", 32'(ctrl0), 0);
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    check("maxb_final_ctrl", 32'(ctrl2), 0);
    check("nolimit_final_en", 32'(en0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
